adder_axi_arb: RTL

ADDER_AXI_ARB -- requirements
Module: adder_axi_arb

---
 rtl/adder_axi_arb_if.sv | 31 +++
 rtl/adder_axi_arb.sv | 94 +++++++++
 2 files changed

// File: rtl/adder_axi_arb_if.sv
// Stream bundle for adder_axi_arb: two requester operand channels and one result channel.
interface adder_axi_arb_if #(
  parameter int DW = 32
);
  logic            s_axis_r0_tvalid;
  logic            s_axis_r0_tready;
  logic [2*DW-1:0] s_axis_r0_tdata;
  logic            s_axis_r1_tvalid;
  logic            s_axis_r1_tready;
  logic [2*DW-1:0] s_axis_r1_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tuser;

  modport slave (
    input  s_axis_r0_tvalid, s_axis_r0_tdata,
    input  s_axis_r1_tvalid, s_axis_r1_tdata,
    input  m_axis_tready,
    output s_axis_r0_tready, s_axis_r1_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tuser
  );

  modport master (
    output s_axis_r0_tvalid, s_axis_r0_tdata,
    output s_axis_r1_tvalid, s_axis_r1_tdata,
    output m_axis_tready,
    input  s_axis_r0_tready, s_axis_r1_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tuser
  );
endinterface

// File: rtl/adder_axi_arb.sv
// Two-requester round-robin saturating adder with a single-entry result register.
// Optional ADDER_AXI_ARB_SATCNT_EN adds a 16-bit saturation event counter (sat_cnt).
module adder_axi_arb #(
  parameter int DW  = 32,
  parameter int ADW = 14
) (
  input  logic          aclk,
  input  logic          rstn_i,
`ifdef ADDER_AXI_ARB_SATCNT_EN
  output logic [15:0]   sat_cnt,
`endif
  adder_axi_arb_if.slave bus
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic          state;
  logic          last_grant;
  logic [DW-1:0] res_q;
  logic          user_q;

  logic          v0, v1;
  logic          xfer_ok;
  logic          gnt;
  logic          accept;
  logic [2*DW-1:0] sel_data;
  logic [ADW-1:0]  op_a, op_b;
  logic [ADW:0]    sum;
  logic [ADW-1:0]  res;
  logic            sat;

  assign v0 = bus.s_axis_r0_tvalid;
  assign v1 = bus.s_axis_r1_tvalid;

  // Output register frees up in the same cycle it is drained; reset blocks all acceptance.
  assign xfer_ok = rstn_i && ((state == EMPTY) || bus.m_axis_tready);
  assign gnt     = (v0 && v1) ? ~last_grant : v1;
  assign accept  = xfer_ok && (v0 || v1);

  assign bus.s_axis_r0_tready = xfer_ok && v0 && !gnt;
  assign bus.s_axis_r1_tready = xfer_ok && v1 && gnt;

  assign sel_data = gnt ? bus.s_axis_r1_tdata : bus.s_axis_r0_tdata;
  assign op_a     = sel_data[ADW-1:0];
  assign op_b     = sel_data[DW+ADW-1:DW];
  assign sum      = {op_a[ADW-1], op_a} + {op_b[ADW-1], op_b};
  assign sat      = sum[ADW] ^ sum[ADW-1];

  always_comb begin
    res = sum[ADW-1:0];
    case (sum[ADW:ADW-1])
      2'b01:   res = {1'b0, {(ADW-1){1'b1}}};
      2'b10:   res = {1'b1, {(ADW-1){1'b0}}};
      default: res = sum[ADW-1:0];
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!rstn_i) begin
      state      <= EMPTY;
      res_q      <= '0;
      user_q     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= FULL;
      res_q      <= {{(DW-ADW){res[ADW-1]}}, res};
      user_q     <= gnt;
      last_grant <= gnt;
    end else if (bus.m_axis_tready) begin
      state      <= EMPTY;
    end
  end

`ifdef ADDER_AXI_ARB_SATCNT_EN
  always_ff @(posedge aclk) begin
    if (!rstn_i) begin
      sat_cnt <= '0;
    end else if (accept && sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

  assign bus.m_axis_tvalid = (state == FULL);
  assign bus.m_axis_tdata  = res_q;
  assign bus.m_axis_tuser  = user_q;

  // Operand bits above ADW are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.s_axis_r0_tdata[2*DW-1:DW+ADW], bus.s_axis_r0_tdata[DW-1:ADW],
                         bus.s_axis_r1_tdata[2*DW-1:DW+ADW], bus.s_axis_r1_tdata[DW-1:ADW]};

endmodule
